// File: rtl/display_pkg.sv
// Shared constants and the leading-zero blanking helper for the display pager.
package display_pkg;

    localparam int NUM_DIGITS       = 4;
    localparam int NIBBLE_W         = 4;
    localparam int DEFAULT_DEBOUNCE = 50000;

    localparam logic PAGE_LO = 1'b0;
    localparam logic PAGE_HI = 1'b1;

    // Digit 0 is never blanked so an all-zero half still shows a single "0".
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
        input logic [NUM_DIGITS*NIBBLE_W-1:0] digits
    );
        logic                  run;
        logic [NUM_DIGITS-1:0] mask;
        run  = 1'b1;
        mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run     = run && (digits[i*NIBBLE_W +: NIBBLE_W] == '0);
            mask[i] = run;
        end
        return mask;
    endfunction

endpackage

// File: rtl/display_pager_key_debounce.sv
// Synchronizes and debounces an active-low pushbutton; emits one pulse per accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic          stable;
    logic [CW-1:0] count;

    // Counter only advances while the synced level disagrees with stable, so it tops out at CNT_LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0  <= 1'b1;
            sync1  <= 1'b1;
            stable <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync0 <= key_n;
            sync1 <= sync0;
            press <= 1'b0;
            if (sync1 == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= sync1;
                count  <= '0;
                press  <= stable & ~sync1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_pager.sv
// Holds a 32-bit word and shows one 16-bit half as four digit nibbles; a key flips the half.
module display_pager
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int LZB             = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [31:0]                    data_in,
    input  logic                           key_n,
    output logic [NUM_DIGITS*NIBBLE_W-1:0] nibbles,
    output logic [NUM_DIGITS-1:0]          blank,
    output logic                           page
);

    logic [31:0] word;
    logic        press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_n),
        .press(press)
    );

    // Load and press are independent, so both land when they coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            page <= PAGE_LO;
        end else begin
            if (load) begin
                word <= data_in;
            end
            if (press) begin
                page <= ~page;
            end
        end
    end

    always_comb begin
        nibbles = (page == PAGE_HI) ? word[31:16] : word[15:0];
        blank   = '0;
        if (LZB != 0) begin
            blank = lead_zero_mask(nibbles);
        end
    end

endmodule

// File: tb/tb_display_pager.sv
// Directed bench for display_pager with a short debounce window.
module tb_display_pager;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] data_in;
    logic        key_n;
    logic [15:0] nibbles;
    logic [3:0]  blank;
    logic        page;
    logic [15:0] nibbles_nz;
    logic [3:0]  blank_nz;
    logic        page_nz;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] exp_nibbles;
        logic [3:0]  exp_blank;
    } load_vec_t;

    load_vec_t vecs[7];

    display_pager #(.DEBOUNCE_CYCLES(4), .LZB(1)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .key_n(key_n),
        .nibbles(nibbles), .blank(blank), .page(page)
    );

    display_pager #(.DEBOUNCE_CYCLES(4), .LZB(0)) dut_nz (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .key_n(key_n),
        .nibbles(nibbles_nz), .blank(blank_nz), .page(page_nz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] d);
        load    = 1'b1;
        data_in = d;
        tick(1);
        load    = 1'b0;
    endtask

    task automatic key_pulse(input int low_cycles, input int settle);
        key_n = 1'b0;
        tick(low_cycles);
        key_n = 1'b1;
        tick(settle);
    endtask

    initial begin
        vecs[0] = '{32'h1234_00A5, 16'h00A5, 4'b1100};
        vecs[1] = '{32'h0000_0000, 16'h0000, 4'b1110};
        vecs[2] = '{32'hFFFF_0F00, 16'h0F00, 4'b1000};
        vecs[3] = '{32'h0000_8000, 16'h8000, 4'b0000};
        vecs[4] = '{32'h1111_0001, 16'h0001, 4'b1110};
        vecs[5] = '{32'h0000_0010, 16'h0010, 4'b1100};
        vecs[6] = '{32'h1234_00A5, 16'h00A5, 4'b1100};

        rst     = 1'b1;
        load    = 1'b0;
        data_in = '0;
        key_n   = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("reset_nibbles", nibbles, 16'h0000);
        check("reset_blank_lzb1", blank, 4'b1110);
        check("reset_blank_lzb0", blank_nz, 4'b0000);
        check("reset_page", page, 1'b0);

        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].data);
            check($sformatf("vec%0d_nibbles", i), nibbles, vecs[i].exp_nibbles);
            check($sformatf("vec%0d_blank", i), blank, vecs[i].exp_blank);
            check($sformatf("vec%0d_blank_lzb0", i), blank_nz, 4'b0000);
            check($sformatf("vec%0d_page", i), page, 1'b0);
        end

        tick(3);
        check("hold_nibbles", nibbles, 16'h00A5);

        // Long press: one toggle to the upper half.
        key_n = 1'b0;
        tick(6);
        check("press_page_before_toggle", page, 1'b0);
        tick(1);
        check("press_page_after_toggle", page, 1'b1);
        tick(3);
        key_n = 1'b1;
        tick(10);
        check("press1_page", page, 1'b1);
        check("press1_nibbles", nibbles, 16'h1234);
        check("press1_blank", blank, 4'b0000);

        key_pulse(10, 10);
        check("press2_page", page, 1'b0);
        check("press2_nibbles", nibbles, 16'h00A5);

        // Glitches shorter than the debounce window.
        key_pulse(1, 6);
        key_pulse(2, 6);
        key_pulse(3, 6);
        check("glitch_page", page, 1'b0);
        check("glitch_nibbles", nibbles, 16'h00A5);

        // Held key far longer than the window still toggles once.
        key_pulse(40, 10);
        check("long_hold_page", page, 1'b1);
        key_pulse(10, 10);
        check("back_to_lo_page", page, 1'b0);

        // Load coinciding with the press pulse.
        key_n = 1'b0;
        tick(6);
        check("coincide_page_before", page, 1'b0);
        load    = 1'b1;
        data_in = 32'hDEAD_BEEF;
        tick(1);
        load    = 1'b0;
        check("coincide_page", page, 1'b1);
        check("coincide_nibbles", nibbles, 16'hDEAD);
        check("coincide_blank", blank, 4'b0000);
        key_n = 1'b1;
        tick(10);
        check("coincide_settled_page", page, 1'b1);

        // Reset in the middle of a key-low run, with a competing load.
        key_n = 1'b0;
        tick(2);
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 32'hFFFF_FFFF;
        tick(3);
        check("rst_page", page, 1'b0);
        check("rst_nibbles", nibbles, 16'h0000);
        rst  = 1'b0;
        load = 1'b0;
        tick(6);
        check("post_rst_page_before", page, 1'b0);
        check("post_rst_word_cleared", nibbles, 16'h0000);
        check("post_rst_blank", blank, 4'b1110);
        tick(1);
        check("post_rst_page_toggled", page, 1'b1);
        check("post_rst_hi_nibbles", nibbles, 16'h0000);
        check("post_rst_hi_blank", blank, 4'b1110);
        check("post_rst_hi_blank_lzb0", blank_nz, 4'b0000);
        key_n = 1'b1;
        tick(10);
        check("post_rst_settled_page", page, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_pager.md
DISPLAY_PAGER -- requirements
Module: display_pager

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the cycles of stable key level required to accept a change (1 ms at 50 MHz).
REQ-003 Parameter LZB, default 1, SHALL enable leading-zero blanking when 1 and disable it when 0.
REQ-004 Port clk  in  1  SHALL be the system clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  SHALL be the synchronous active-high reset.
REQ-006 Port load  in  1  SHALL be a capture strobe for data_in.
REQ-007 Port data_in  in  32  SHALL be the word to display, for example a core register or PC.
REQ-008 Port key_n  in  1  SHALL be the raw, asynchronous, active-low page pushbutton.
REQ-009 Port nibbles  out  16  SHALL carry four 4-bit digit codes; [3:0] is the rightmost digit and feeds one 7-segment decoder per nibble.
REQ-010 Port blank  out  4  SHALL mark digits the board wrapper forces dark (all segments 1); bit i corresponds to nibble i.
REQ-011 Port page  out  1  SHALL indicate the displayed half: 0 = word[15:0], 1 = word[31:16].

Function
REQ-012 On a clk edge with load=1, word SHALL capture data_in; nibbles and blank SHALL reflect the new word from the next cycle (latency 1).
REQ-013 With load=0, word SHALL hold its value indefinitely.
REQ-014 key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The debouncer SHALL hold a stable level and a counter: counter clears whenever the synced level equals stable, else increments; on reaching DEBOUNCE_CYCLES-1 with mismatch, stable takes the synced level and counter clears.
REQ-016 Any mismatch run shorter than DEBOUNCE_CYCLES SHALL leave stable unchanged (glitch rejection).
REQ-017 A stable 1->0 transition SHALL produce exactly one single-cycle press pulse; the 0->1 release SHALL produce none.
REQ-018 Each press pulse SHALL toggle page on the same edge the pulse is registered; the output changes one cycle after the pulse.
REQ-019 nibbles SHALL equal word[15:0] when page=0 and word[31:16] when page=1, decoded combinationally from the registered word and page.
REQ-020 With LZB=1, blank[i] for i=1..3 SHALL be 1 iff displayed nibble i and all higher displayed nibbles are 0; blank[0] SHALL always be 0.
REQ-021 With LZB=0, blank SHALL be 4'b0000.
REQ-022 A load and a press pulse in the same cycle SHALL both take effect: the new word is shown on the toggled page.
REQ-023 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap: it is bounded by DEBOUNCE_CYCLES-1.
REQ-024 Holding the key pressed indefinitely SHALL yield one toggle only.

Reset
REQ-025 While rst=1, the following SHALL be reset: word=0, page=0, synchronizer flops=1, stable=1, counter=0, press=0.
REQ-026 After reset, outputs SHALL be nibbles=16'h0000, blank=4'b1110 (LZB=1) or 4'b0000 (LZB=0), and page=0.
REQ-027 Reset asserted during a debounce run SHALL abandon it; a key still held at reset release SHALL be accepted as a press after DEBOUNCE_CYCLES cycles.
REQ-028 rst SHALL take priority over load and press in the same cycle.

Structure
REQ-029 Package display_pkg SHALL hold NUM_DIGITS=4, NIBBLE_W=4, DEFAULT_DEBOUNCE=50000, and the page encoding constants PAGE_LO=0 and PAGE_HI=1.
REQ-030 The synchronizer, debouncer and press-edge logic SHALL form one sub-module, key_debounce (clk, rst, key_n -> press), reusable for other board keys.
REQ-031 Digit-to-segment decoding SHALL stay outside this block, with one decoder instance per nibble in the board top.

Verification
Benches SHALL use DEBOUNCE_CYCLES=4.
REQ-032 Scenario: reset, then load=1 with data_in=32'h1234_00A5 -> next cycle nibbles=16'h00A5, blank=4'b1100, page=0.
REQ-033 Scenario: key_n held 0 for 10 cycles -> exactly one press pulse -> nibbles=16'h1234, blank=4'b0000, page=1; release then press again -> page=0.
REQ-034 Scenario: key_n low pulses of 1, 2 and 3 cycles separated by highs -> no press, page unchanged.
REQ-035 Scenario: load of 32'hDEAD_BEEF in the same cycle as a press pulse, page=0 before -> nibbles=16'hDEAD, page=1.
REQ-036 Scenario: rst asserted 2 cycles into a key-low run, key still held -> no toggle during reset; one toggle occurs 4+2 sync cycles after release of reset.
REQ-037 Scenario: LZB=0 with word=0 -> blank=4'b0000; LZB=1 with displayed half 16'h0000 -> blank=4'b1110.
